// File: rtl/tri_debug_trace_capture.sv
// Debug trace sink: circular capture buffer with pattern/external trigger, post-trigger window and valid/ready drain.
// Optional build macro TRI_DBG_CAPTURE_DEDUP_EN suppresses storing a qualified sample equal to the last stored one.
module tri_debug_trace_capture #(
    parameter int DBG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic                  i_rd_start,
    input  logic [0:DBG_WIDTH-1]  i_trace_data_in,
    input  logic [3:0]            i_coretrace_ctrls_in,
    input  logic [0:DBG_WIDTH-1]  i_trig_mask,
    input  logic [0:DBG_WIDTH-1]  i_trig_pattern,
    input  logic [ADDR_WIDTH-1:0] i_post_count,
    input  logic                  i_rd_ready,
    output logic                  o_rd_valid,
    output logic [0:DBG_WIDTH-1]  o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wrapped,
    output logic [ADDR_WIDTH-1:0] o_trig_offset
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t                r_state;
    logic [0:DBG_WIDTH-1]  r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_trig_ptr;
    logic [ADDR_WIDTH-1:0] r_post_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH:0]   r_rd_left;
    logic                  r_wrapped;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [0:DBG_WIDTH-1]  r_rd_data;
    logic [ADDR_WIDTH-1:0] r_trig_offset;

    logic                  w_qual;
    logic                  w_match;
    logic                  w_trig;
    logic                  w_keep;
    logic                  w_wr_en;
    logic                  w_ptr_top;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic                  w_wrapped_nxt;
    logic [ADDR_WIDTH-1:0] w_trig_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_trig_offset;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_unused;

    assign w_unused  = ^i_coretrace_ctrls_in[3:2];
    // arm/abort/rst take precedence over a sample arriving in the same cycle
    assign w_qual    = i_coretrace_ctrls_in[0] & ~i_rst & ~i_abort & ~i_arm &
                       ((r_state == S_ARMED) | (r_state == S_POST));
    assign w_match   = (((i_trace_data_in ^ i_trig_pattern) & i_trig_mask) == {DBG_WIDTH{1'b0}});
    assign w_trig    = (r_state == S_ARMED) &
                       ((i_coretrace_ctrls_in[0] & w_match) | i_coretrace_ctrls_in[1]);
    assign w_wr_en   = w_qual & w_keep;
    assign w_ptr_top = (r_wr_ptr == {ADDR_WIDTH{1'b1}});

    // Offset is formed from the post-write pointer state so it is correct on the DONE entry edge
    assign w_wr_ptr_nxt   = w_wr_en ? (r_wr_ptr + ADDR_WIDTH'(1)) : r_wr_ptr;
    assign w_wrapped_nxt  = r_wrapped | (w_wr_en & w_ptr_top);
    assign w_trig_ptr_nxt = (r_state == S_ARMED) ? r_wr_ptr : r_trig_ptr;
    assign w_trig_offset  = w_trig_ptr_nxt - (w_wrapped_nxt ? w_wr_ptr_nxt : {ADDR_WIDTH{1'b0}});
    assign w_start        = r_wrapped ? r_wr_ptr : {ADDR_WIDTH{1'b0}};
    assign w_count        = r_wrapped ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, r_wr_ptr};

`ifdef TRI_DBG_CAPTURE_DEDUP_EN
    logic [0:DBG_WIDTH-1] r_last_sample;
    logic                 r_first;

    assign w_keep = r_first | w_trig | (i_trace_data_in != r_last_sample);

    // Tracks the most recently stored sample and whether anything has been stored since arm
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_first       <= 1'b0;
            r_last_sample <= {DBG_WIDTH{1'b0}};
        end else if (i_arm & ~i_abort) begin
            r_first <= 1'b1;
        end else if (w_wr_en) begin
            r_first       <= 1'b0;
            r_last_sample <= i_trace_data_in;
        end
    end
`else
    assign w_keep = 1'b1;
`endif

    // Capture buffer write port; contents survive reset and abort
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_trace_data_in;
        end
    end

    // Capture/drain state machine with registered status and read outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= {ADDR_WIDTH{1'b0}};
            r_trig_ptr    <= {ADDR_WIDTH{1'b0}};
            r_post_cnt    <= {ADDR_WIDTH{1'b0}};
            r_rd_addr     <= {ADDR_WIDTH{1'b0}};
            r_rd_left     <= {(ADDR_WIDTH+1){1'b0}};
            r_wrapped     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_data     <= {DBG_WIDTH{1'b0}};
            r_trig_offset <= {ADDR_WIDTH{1'b0}};
        end else if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else if (i_arm) begin
            r_state       <= S_ARMED;
            r_wr_ptr      <= {ADDR_WIDTH{1'b0}};
            r_wrapped     <= 1'b0;
            r_post_cnt    <= {ADDR_WIDTH{1'b0}};
            r_trig_offset <= {ADDR_WIDTH{1'b0}};
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            case (r_state)
                S_ARMED, S_POST: begin
                    r_wr_ptr  <= w_wr_ptr_nxt;
                    r_wrapped <= w_wrapped_nxt;
                    if (r_state == S_ARMED) begin
                        if (w_trig) begin
                            r_trig_ptr <= r_wr_ptr;
                            r_post_cnt <= i_post_count;
                            if (i_post_count == {ADDR_WIDTH{1'b0}}) begin
                                r_state       <= S_DONE;
                                r_busy        <= 1'b0;
                                r_done        <= 1'b1;
                                r_trig_offset <= w_trig_offset;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end else if (w_wr_en) begin
                        r_post_cnt <= r_post_cnt - ADDR_WIDTH'(1);
                        if (r_post_cnt == ADDR_WIDTH'(1)) begin
                            r_state       <= S_DONE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_trig_offset <= w_trig_offset;
                        end
                    end
                end
                S_DONE: begin
                    if (i_rd_start) begin
                        r_state   <= S_READ;
                        r_done    <= 1'b0;
                        r_rd_addr <= w_start;
                        r_rd_left <= w_count;
                    end
                end
                S_READ: begin
                    // Output register refills on the acceptance edge, giving one word per cycle
                    if (r_rd_valid & i_rd_ready & r_rd_last) begin
                        r_state    <= S_IDLE;
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                    end else if (~r_rd_valid | i_rd_ready) begin
                        if (r_rd_left != {(ADDR_WIDTH+1){1'b0}}) begin
                            r_rd_data  <= r_mem[r_rd_addr];
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= (r_rd_left == (ADDR_WIDTH+1)'(1));
                            r_rd_addr  <= r_rd_addr + ADDR_WIDTH'(1);
                            r_rd_left  <= r_rd_left - (ADDR_WIDTH+1)'(1);
                        end else begin
                            r_state    <= S_IDLE;
                            r_rd_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_rd_last     = r_rd_last;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_wrapped     = r_wrapped;
    assign o_trig_offset = r_trig_offset;

endmodule

// File: tb/tb_tri_debug_trace_capture.sv
// Directed bench for tri_debug_trace_capture: a vector table for the basic capture/drain plus hand-written corner sequences.
module tb_tri_debug_trace_capture;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_arm = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_rd_start = 1'b0;
    logic [0:31] i_trace_data_in = 32'h0;
    logic [3:0]  i_coretrace_ctrls_in = 4'h0;
    logic [0:31] i_trig_mask = 32'hFFFF_FFFF;
    logic [0:31] i_trig_pattern = 32'hFFFF_FFFF;
    logic [4:0]  i_post_count = 5'd0;
    logic        i_rd_ready = 1'b0;
    logic        o_rd_valid;
    logic [0:31] o_rd_data;
    logic        o_rd_last;
    logic        o_busy;
    logic        o_done;
    logic        o_wrapped;
    logic [4:0]  o_trig_offset;

    int n_vec = 0;
    int n_err = 0;

    tri_debug_trace_capture #(.DBG_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_arm(i_arm), .i_abort(i_abort), .i_rd_start(i_rd_start),
        .i_trace_data_in(i_trace_data_in), .i_coretrace_ctrls_in(i_coretrace_ctrls_in),
        .i_trig_mask(i_trig_mask), .i_trig_pattern(i_trig_pattern), .i_post_count(i_post_count),
        .i_rd_ready(i_rd_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
        .o_busy(o_busy), .o_done(o_done), .o_wrapped(o_wrapped), .o_trig_offset(o_trig_offset)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        arm;
        logic        rd_start;
        logic        rd_ready;
        logic [3:0]  ctrls;
        logic [31:0] data;
        logic        e_busy;
        logic        e_done;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];

    function automatic void push(logic arm, logic rd_start, logic rd_ready, logic [3:0] ctrls,
                                 logic [31:0] data, logic eb, logic ed, logic ev,
                                 logic [31:0] edata, logic el);
        vec_t v;
        v.arm = arm; v.rd_start = rd_start; v.rd_ready = rd_ready; v.ctrls = ctrls; v.data = data;
        v.e_busy = eb; v.e_done = ed; v.e_valid = ev; v.e_data = edata; v.e_last = el;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input logic [3:0] ctrls, input logic [31:0] data);
        i_coretrace_ctrls_in = ctrls;
        i_trace_data_in = data;
        step();
        i_coretrace_ctrls_in = 4'h0;
    endtask

    task automatic arm_pulse();
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
    endtask

    // Starts a drain from DONE and checks every presented word against exp_q in order
    task automatic drain(input string tag, input bit stall);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        i_rd_ready = 1'b0;
        i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        while (idx < exp_q.size() && cyc < 200) begin
            if (o_rd_valid) begin
                chk({tag, " data"}, o_rd_data, exp_q[idx]);
                chk({tag, " last"}, o_rd_last, (idx == exp_q.size() - 1));
            end
            i_rd_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            acc = o_rd_valid & i_rd_ready;
            step();
            cyc++;
            if (acc) idx++;
        end
        i_rd_ready = 1'b0;
        chk({tag, " count"}, idx, exp_q.size());
        chk({tag, " valid_after"}, o_rd_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fed;

        // Capture 0..9, external trigger on 0xA, 3 post samples, then drain at full rate
        push(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) push(1'b0, 1'b0, 1'b0, 4'h1, 32'(i), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 4'h3, 32'hA, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 4'h1, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 4'h1, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 4'h1, 32'hD, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 14; k++) push(1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(k), (k == 13));
        push(1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        step();
        step();
        chk("reset valid", o_rd_valid, 1'b0);
        chk("reset busy", o_busy, 1'b0);
        chk("reset done", o_done, 1'b0);
        chk("reset wrapped", o_wrapped, 1'b0);
        chk("reset offset", o_trig_offset, 5'd0);
        chk("reset last", o_rd_last, 1'b0);
        i_rst = 1'b0;
        step();

        i_trig_mask = 32'hFFFF_FFFF;
        i_trig_pattern = 32'hFFFF_FFFF;
        i_post_count = 5'd3;
        for (int k = 0; k < tbl.size(); k++) begin
            i_arm = tbl[k].arm;
            i_rd_start = tbl[k].rd_start;
            i_rd_ready = tbl[k].rd_ready;
            i_coretrace_ctrls_in = tbl[k].ctrls;
            i_trace_data_in = tbl[k].data;
            step();
            chk($sformatf("t1[%0d] busy", k), o_busy, tbl[k].e_busy);
            chk($sformatf("t1[%0d] done", k), o_done, tbl[k].e_done);
            chk($sformatf("t1[%0d] valid", k), o_rd_valid, tbl[k].e_valid);
            if (tbl[k].e_valid) begin
                chk($sformatf("t1[%0d] data", k), o_rd_data, tbl[k].e_data);
                chk($sformatf("t1[%0d] last", k), o_rd_last, tbl[k].e_last);
            end
        end
        i_arm = 1'b0; i_rd_start = 1'b0; i_rd_ready = 1'b0; i_coretrace_ctrls_in = 4'h0;
        chk("t1 trig_offset", o_trig_offset, 5'd10);
        chk("t1 wrapped", o_wrapped, 1'b0);

        // Pattern trigger after the buffer has wrapped; 31 post samples
        i_trig_mask = 32'hFFFF_0000;
        i_trig_pattern = 32'hABCD_0000;
        i_post_count = 5'd31;
        arm_pulse();
        fed = 0;
        while (!o_done && fed < 200) begin
            sample(4'h1, (fed == 35) ? 32'hABCD_0000 : 32'(fed));
            fed++;
        end
        chk("t2 samples_to_done", fed, 67);
        chk("t2 wrapped", o_wrapped, 1'b1);
        chk("t2 trig_offset", o_trig_offset, 5'd0);
        exp_q.delete();
        exp_q.push_back(32'hABCD_0000);
        for (int i = 36; i < 67; i++) exp_q.push_back(32'(i));
        drain("t2 drain", 1'b0);

        // Abort during POST
        i_trig_mask = 32'hFFFF_FFFF;
        i_trig_pattern = 32'hFFFF_FFFF;
        i_post_count = 5'd5;
        arm_pulse();
        sample(4'h3, 32'h1);
        sample(4'h1, 32'h2);
        chk("t4 busy_in_post", o_busy, 1'b1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("t4 abort busy", o_busy, 1'b0);
        chk("t4 abort done", o_done, 1'b0);

        // Arm wins over rd_start in DONE
        i_post_count = 5'd0;
        arm_pulse();
        sample(4'h2, 32'h9);
        chk("t4 ext_only done", o_done, 1'b1);
        i_arm = 1'b1;
        i_rd_start = 1'b1;
        step();
        i_arm = 1'b0;
        i_rd_start = 1'b0;
        chk("t4 arm+rd busy", o_busy, 1'b1);
        chk("t4 arm+rd done", o_done, 1'b0);
        step();
        chk("t4 arm+rd valid", o_rd_valid, 1'b0);

        // Reset during READ
        sample(4'h1, 32'h11);
        sample(4'h3, 32'h22);
        chk("t4 done_before_read", o_done, 1'b1);
        i_rd_ready = 1'b0;
        i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        step();
        chk("t4 read valid", o_rd_valid, 1'b1);
        chk("t4 read data", o_rd_data, 32'h11);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("t4 rst valid", o_rd_valid, 1'b0);
        chk("t4 rst offset", o_trig_offset, 5'd0);
        step();
        chk("t4 rst idle valid", o_rd_valid, 1'b0);
        chk("t4 rst idle done", o_done, 1'b0);

        // Unqualified cycles in POST leave the window untouched; stalled drain
        i_post_count = 5'd2;
        arm_pulse();
        sample(4'h1, 32'h100);
        sample(4'h1, 32'h101);
        sample(4'h3, 32'h102);
        for (int i = 0; i < 5; i++) begin
            sample(4'h0, 32'h200 + 32'(i));
            chk($sformatf("t5 gap[%0d] done", i), o_done, 1'b0);
        end
        sample(4'h1, 32'h103);
        chk("t5 done_early", o_done, 1'b0);
        sample(4'h1, 32'h104);
        chk("t5 done", o_done, 1'b1);
        chk("t5 trig_offset", o_trig_offset, 5'd2);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + 32'(i));
        drain("t3 stall drain", 1'b1);

        // mask=0 with post_count=0: first qualified sample triggers, one entry
        i_trig_mask = 32'h0;
        i_post_count = 5'd0;
        arm_pulse();
        sample(4'h1, 32'h55);
        chk("t5 post0 done", o_done, 1'b1);
        chk("t5 post0 offset", o_trig_offset, 5'd0);
        exp_q.delete();
        exp_q.push_back(32'h55);
        drain("t5 post0 drain", 1'b0);

        // External trigger only: nothing stored, drain produces no words
        i_trig_mask = 32'hFFFF_FFFF;
        arm_pulse();
        sample(4'h2, 32'h66);
        chk("t5 ext0 done", o_done, 1'b1);
        i_rd_ready = 1'b1;
        i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        chk("t5 ext0 read valid", o_rd_valid, 1'b0);
        step();
        chk("t5 ext0 idle valid", o_rd_valid, 1'b0);
        chk("t5 ext0 idle done", o_done, 1'b0);
        i_rd_ready = 1'b0;

`ifdef TRI_DBG_CAPTURE_DEDUP_EN
        // Repeated samples are suppressed except first-after-arm and the trigger sample
        i_post_count = 5'd2;
        arm_pulse();
        sample(4'h1, 32'h5);
        sample(4'h1, 32'h5);
        sample(4'h1, 32'h5);
        sample(4'h1, 32'h7);
        sample(4'h1, 32'h7);
        sample(4'h3, 32'h7);
        sample(4'h1, 32'h7);
        sample(4'h1, 32'h8);
        chk("t6 done_early", o_done, 1'b0);
        sample(4'h1, 32'h9);
        chk("t6 done", o_done, 1'b1);
        chk("t6 trig_offset", o_trig_offset, 5'd2);
        exp_q.delete();
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'h9);
        drain("t6 dedup drain", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
